// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a framed byte stream (length, payload, XOR checksum),
// writes the payload from byte address 0 and holds the CPU in reset until a verified load.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 36
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q;
    logic [7:0]  len_hi_q;
    logic [7:0]  csum_q;
    logic [31:0] cnt_q;
    logic [31:0] last_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        cpu_reset_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] words_q;

    logic        accept;
    logic [31:0] len_bytes_d;

    always_comb begin
        rx_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CSUM);
    end

    assign accept = rx_valid && rx_ready;

    // Byte count 4*N held in 32 bits so an oversize length is never truncated.
    assign len_bytes_d = {14'b0, len_hi_q, rx_data, 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_hi_q    <= '0;
            csum_q      <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q     <= S_LEN_HI;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        words_q     <= '0;
                        cnt_q       <= '0;
                        csum_q      <= '0;
                        cpu_reset_q <= 1'b0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= rx_data;
                        state_q  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        last_q <= len_bytes_d - 32'd1;
                        if (len_bytes_d > MEM_BYTES) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else if (len_bytes_d == '0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q;
                        mem_wdata_q <= rx_data;
                        csum_q      <= csum_q ^ rx_data;
                        cnt_q       <= cnt_q + 32'd1;
                        if (cnt_q[1:0] == 2'd3) begin
                            words_q <= words_q + 16'd1;
                        end
                        if (cnt_q == last_q) begin
                            state_q <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory over a byte-wide write port. It takes a framed byte stream (length, payload, checksum) on a valid/ready interface. Payload bytes go to consecutive byte addresses starting at 0, so stream order equals big-endian word order as fetched by PC. While a load is in progress the loader holds the processor in reset, and it releases the processor only after a verified load.

## Interface
- MEM_BYTES, 36: instruction memory depth in bytes; upper bound for 4*N.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  pulse; begins a load session (honoured only in IDLE, DONE, ERR).
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  byte write strobe to instruction memory.
- mem_addr  output  32  byte address (same width as PC).
- mem_wdata  output  8  byte to write.
- cpu_reset  output  1  active-low reset to the processor; 0 = hold.
- done  output  1  load completed and checksum matched.
- error  output  1  load aborted (oversize or checksum mismatch).
- words_loaded  output  16  count of complete 4-byte words written this session.

## Operation
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - 4*N payload bytes.
  - CSUM: XOR of all payload bytes. Initial value 0x00, so CSUM for N=0 is 0x00.
- A byte is accepted on a rising edge with rx_valid && rx_ready. rx_ready is combinational from state: 1 in LEN_HI, LEN_LO, DATA, CSUM; 0 otherwise.
- States and transitions:
  - IDLE: start -> LEN_HI.
  - LEN_HI: accept -> LEN_LO.
  - LEN_LO: accept, then check the length:
    - 4*N > MEM_BYTES -> ERR. Compute with at least 18 bits, no truncation.
    - N == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: each accept writes one byte and XORs it into the running checksum. Acceptance of byte 4*N-1 -> CSUM.
  - CSUM: accept. If the byte equals the running XOR -> DONE, else -> ERR.
  - DONE / ERR: start -> LEN_HI. A new session clears done, error, words_loaded, the byte address and the checksum.
- start in LEN_HI/LEN_LO/DATA/CSUM is ignored.
- Byte counter: resets to 0 at start and addresses the writes.
- words_loaded: increments when the write of a byte at address[1:0]==3 is issued.
- cpu_reset:
  - 0 in every state except DONE.
  - 1 in DONE.
  - Returns to 0 the cycle after start is taken from DONE.
- In ERR, memory keeps whatever bytes were already written. The processor stays held.

## Timing
- Reset (reset==0 at an edge) forces state IDLE and sets every output to 0:
  - rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=0, done=0, error=0, words_loaded=0.
- Reset has priority over start and rx_valid.
- Write latency is 1 cycle. A data byte accepted at edge k drives mem_we=1, mem_addr and mem_wdata from the registers after edge k, for exactly one cycle (until edge k+1).
- Back-to-back acceptance gives one write per cycle at sustained rate. mem_we is never high in two consecutive cycles for the same address.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- done, error and cpu_reset change in the cycle after the CSUM or LEN_LO acceptance that decides them. The final payload write completes no later than the cycle in which done rises.
- Reset mid-load:
  - Returns to IDLE.
  - Any write already registered is dropped: mem_we=0 after the reset edge.
  - No further writes occur.
  - Partial memory contents are left as written.
- rx_valid gaps are allowed anywhere, with no timeout. The loader waits indefinitely.

## Test plan
- Reset values: hold reset=0 for 2 cycles with start=1 and rx_valid=1 -> all outputs 0, no mem_we, state stays IDLE after release until a new start.
- Good load, MEM_BYTES=36:
  - Stimulus: start, then stream 00 02 8C 01 00 00 8C 02 00 01 02.
  - Required: eight writes at addr 0..7 with data 8C 01 00 00 8C 02 00 01.
  - Required: words_loaded=2, done=1, error=0, cpu_reset=1.
- Checksum mismatch: same stream with final byte 03 -> same eight writes, then error=1, done=0, cpu_reset=0, words_loaded=2.
- Oversize: stream 00 0A (40 > 36) -> error=1 after LEN_LO, zero mem_we pulses, rx_ready=0. Boundary 00 09 (36 bytes) is accepted.
- Empty program plus backpressure: stream 00 00 00 with rx_valid toggling every other cycle -> done=1, no writes, words_loaded=0. Repeat with start from DONE -> cpu_reset drops to 0 the next cycle.
- Reset mid-load: assert reset after the 3rd payload byte is accepted -> at most 2 writes are seen, no writes after the reset edge, words_loaded=0. Then the good-load scenario completes correctly.
